uart_rx_shift: RTL and testbench
================================

UART_RX_SHIFT -- requirements
Module: uart_rx_shift

Interface
REQ-001 rstn_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-002 bclk_in  input  1  SHALL be the single clock, an oversampling clock at N x baud; all logic SHALL be on its rising edge.
REQ-003 enable_in  input  1  SHALL be the receiver enable; low aborts reception.
REQ-004 serial_in  input  1  SHALL be the asynchronous serial line; idle is high.
REQ-005 osm_sel_in  input  1  SHALL select oversampling N: 0 = 16, 1 = 13.
REQ-006 wls_in  input  2  SHALL select word length: 0..3 = 5..8 data bits.
REQ-007 pen_in  input  1  SHALL enable the parity bit.
REQ-008 esp_in  input  1  SHALL select even parity; 0 selects odd.
REQ-009 sp_in  input  1  SHALL select stick parity.
REQ-010 rbr_out  output  8  SHALL carry the received word, LSB-aligned, with unused upper bits 0.
REQ-011 valid_out  output  1  SHALL pulse for one cycle per completed frame.
REQ-012 pe_out / fe_out / bi_out  output  1 each  SHALL flag parity error, framing error and break for the word on rbr_out.
REQ-013 busy_out  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 serial_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use the synchronized value (sync).
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, encoded in 3 bits; any illegal encoding SHALL go to IDLE.
REQ-016 IDLE SHALL register the previous sync value and go to START on a 1->0 transition while enable_in=1, clearing the 4-bit sample counter.
REQ-017 START SHALL sample sync when the counter equals 7 (N=16) or 6 (N=13); if the sample is 1, it SHALL return to IDLE as a false start with no output change; otherwise it SHALL clear the counter and go to DATA.
REQ-018 On START->DATA, wls_in, pen_in, esp_in, sp_in and osm_sel_in SHALL be latched; changes mid-frame SHALL have no effect.
REQ-019 DATA, PARITY and STOP SHALL each count 0..N-1 and sample sync at count N-1, then clear the counter.
REQ-020 DATA SHALL receive wls+5 bits LSB-first into a 3-bit bit counter, then go to PARITY if pen=1, else to STOP.
REQ-021 PARITY SHALL compute the expected bit as: sp=1 -> ~esp; sp=0, esp=1 -> XOR of the data bits; sp=0, esp=0 -> XNOR of the data bits. pe SHALL be set when the sampled bit differs from the expected bit.
REQ-022 STOP SHALL sample the first stop bit only; a second stop bit SHALL never be checked. fe = (sample == 0).
REQ-023 bi SHALL be 1 when all data bits, the parity bit (if enabled) and the stop bit sampled 0.
REQ-024 The cycle after the stop sample, rbr_out, pe_out, fe_out and bi_out SHALL update, valid_out SHALL be 1 for exactly that cycle, and the state SHALL return to IDLE.
REQ-025 Outputs SHALL hold their values until the next valid_out; pe_out SHALL read 0 when pen=0.
REQ-026 After a frame, a new start SHALL require a fresh 1->0 transition; a line held low (break) SHALL not retrigger.
REQ-027 enable_in=0 in any state SHALL go to IDLE on the next edge, with no valid_out and outputs held.
REQ-028 Frame latency from the detecting edge to valid_out SHALL equal M + N*(1 + bits + pen) + 1 cycles, where M is the start sample index from REQ-017 (7 or 6).

Reset
REQ-029 While rstn_in=0, the state SHALL be IDLE, all counters 0, synchronizer flops 1, rbr_out=8'h00, and valid_out, pe_out, fe_out, bi_out and busy_out all 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial word; after release, reception SHALL need a new 1->0 transition.

Verification
REQ-031 N=16, 8N1, send 8'hA5 -> rbr_out=8'hA5, pe=fe=bi=0, valid_out for 1 cycle at latency 7+16*9+1=152.
REQ-032 N=13, wls=0, even parity, send 5'h13 with correct parity -> rbr_out=8'h13, pe=0; flip the parity bit -> pe=1.
REQ-033 Stick parity sp=1, esp=1 with parity bit 1 -> pe=1; with parity bit 0 -> pe=0.
REQ-034 Low glitch of 4 bclk cycles -> false start, busy_out returns to 0, no valid_out.
REQ-035 Line held low for 2 frame times -> one valid_out with rbr=0, fe=1, bi=1, and no second frame until the line goes high then low.
REQ-036 Drop enable_in at data bit 3, or pulse rstn_in -> no valid_out, IDLE on the next edge; the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_shift.sv
// Oversampling UART receiver: synchronizes the serial line, detects a start edge,
// mid-bit samples 5..8 data bits, optional parity and one stop bit, then reports the word.
module uart_rx_shift (
    input  logic       bclk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       serial_in,
    input  logic       osm_sel_in,
    input  logic [1:0] wls_in,
    input  logic       pen_in,
    input  logic       esp_in,
    input  logic       sp_in,
    output logic [7:0] rbr_out,
    output logic       valid_out,
    output logic       pe_out,
    output logic       fe_out,
    output logic       bi_out,
    output logic       busy_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic       sync_meta;
    logic       sync;
    logic       prev;
    logic [2:0] state;
    logic [3:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [1:0] wls;
    logic       pen;
    logic       esp;
    logic       sp;
    logic       osm;
    logic       par_acc;
    logic       all_zero;
    logic       par_err;

    logic [3:0] start_pt;
    logic [3:0] last_cnt;
    logic       sample_pt;
    logic       exp_par;
    logic [2:0] last_bit;

    always_comb begin
        start_pt  = osm_sel_in ? 4'd6 : 4'd7;
        last_cnt  = osm ? 4'd12 : 4'd15;
        sample_pt = (cnt == last_cnt);
        last_bit  = {1'b0, wls} + 3'd4;
        exp_par   = sp ? ~esp : (esp ? par_acc : ~par_acc);
    end

    assign busy_out = (state != IDLE);

    // prev follows sync in every state, so a line still low after a frame cannot retrigger
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            prev      <= 1'b1;
            state     <= IDLE;
            cnt       <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            wls       <= 2'd0;
            pen       <= 1'b0;
            esp       <= 1'b0;
            sp        <= 1'b0;
            osm       <= 1'b0;
            par_acc   <= 1'b0;
            all_zero  <= 1'b0;
            par_err   <= 1'b0;
            rbr_out   <= 8'h00;
            valid_out <= 1'b0;
            pe_out    <= 1'b0;
            fe_out    <= 1'b0;
            bi_out    <= 1'b0;
        end else begin
            sync_meta <= serial_in;
            sync      <= sync_meta;
            prev      <= sync;
            valid_out <= 1'b0;
            if (!enable_in) begin
                state   <= IDLE;
                cnt     <= 4'd0;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (prev && !sync) begin
                            state <= START;
                            cnt   <= 4'd0;
                        end
                    end
                    START: begin
                        if (cnt == start_pt) begin
                            if (sync) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                cnt      <= 4'd0;
                                bit_cnt  <= 3'd0;
                                shift    <= 8'h00;
                                par_acc  <= 1'b0;
                                all_zero <= 1'b1;
                                par_err  <= 1'b0;
                                wls      <= wls_in;
                                pen      <= pen_in;
                                esp      <= esp_in;
                                sp       <= sp_in;
                                osm      <= osm_sel_in;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (sample_pt) begin
                            cnt            <= 4'd0;
                            shift[bit_cnt] <= sync;
                            par_acc        <= par_acc ^ sync;
                            all_zero       <= all_zero & ~sync;
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= 3'd0;
                                state   <= pen ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        if (sample_pt) begin
                            cnt      <= 4'd0;
                            par_err  <= (sync != exp_par);
                            all_zero <= all_zero & ~sync;
                            state    <= STOP;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (sample_pt) begin
                            cnt       <= 4'd0;
                            state     <= IDLE;
                            valid_out <= 1'b1;
                            rbr_out   <= shift;
                            pe_out    <= pen & par_err;
                            fe_out    <= ~sync;
                            bi_out    <= all_zero & ~sync;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_shift.sv
// Directed bench for uart_rx_shift: frames are driven bit-by-bit at N clocks per bit
// and a negedge monitor captures each reported word for the scenario tasks to check.
module tb_uart_rx_shift;

    logic       bclk_in;
    logic       rstn_in;
    logic       enable_in;
    logic       serial_in;
    logic       osm_sel_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       esp_in;
    logic       sp_in;
    logic [7:0] rbr_out;
    logic       valid_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    int passed;
    int total;

    int         cyc;
    int         busy_cyc;
    int         vcount;
    int         rises;
    int         cap_lat;
    logic       busy_q;
    logic [7:0] cap_rbr;
    logic       cap_pe;
    logic       cap_fe;
    logic       cap_bi;

    uart_rx_shift dut (
        .bclk_in    (bclk_in),
        .rstn_in    (rstn_in),
        .enable_in  (enable_in),
        .serial_in  (serial_in),
        .osm_sel_in (osm_sel_in),
        .wls_in     (wls_in),
        .pen_in     (pen_in),
        .esp_in     (esp_in),
        .sp_in      (sp_in),
        .rbr_out    (rbr_out),
        .valid_out  (valid_out),
        .pe_out     (pe_out),
        .fe_out     (fe_out),
        .bi_out     (bi_out),
        .busy_out   (busy_out)
    );

    initial bclk_in = 1'b0;
    always #5 bclk_in = ~bclk_in;

    initial cyc = 0;
    always @(posedge bclk_in) cyc <= cyc + 1;

    initial begin
        vcount = 0; rises = 0; busy_cyc = 0; cap_lat = 0; busy_q = 1'b0;
        cap_rbr = 8'h00; cap_pe = 1'b0; cap_fe = 1'b0; cap_bi = 1'b0;
    end

    // Latency is counted in rising edges from the edge that raised busy to the one that raised valid
    always @(negedge bclk_in) begin
        if (valid_out) begin
            vcount  <= vcount + 1;
            cap_rbr <= rbr_out;
            cap_pe  <= pe_out;
            cap_fe  <= fe_out;
            cap_bi  <= bi_out;
            cap_lat <= cyc - busy_cyc;
        end
        if (busy_out && !busy_q) begin
            busy_cyc <= cyc;
            rises    <= rises + 1;
        end
        busy_q <= busy_out;
    end

    task automatic set_cfg(input logic osm, input logic [1:0] wls, input logic pen,
                           input logic esp, input logic sp);
        osm_sel_in = osm; wls_in = wls; pen_in = pen; esp_in = esp; sp_in = sp;
    endtask

    task automatic drive_frame(input logic [7:0] data, input int nbits, input logic par_en,
                               input logic par_bit, input int n, input int periods);
        logic [10:0] bits_v;
        int          nframe;
        bits_v    = '1;
        bits_v[0] = 1'b0;
        for (int i = 0; i < nbits; i++) bits_v[1 + i] = data[i];
        if (par_en) bits_v[1 + nbits] = par_bit;
        nframe = 2 + nbits + (par_en ? 1 : 0);
        for (int b = 0; b < periods && b < nframe; b++) begin
            serial_in = bits_v[b];
            repeat (n) @(negedge bclk_in);
        end
    endtask

    task automatic test_reset;
        rstn_in = 1'b0;
        repeat (3) @(negedge bclk_in);
        total++; if (rbr_out !== 8'h00) $display("[TB] FAIL reset_rbr: got %h expected 00", rbr_out); else passed++;
        total++; if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); else passed++;
        total++; if (pe_out !== 1'b0) $display("[TB] FAIL reset_pe: got %b expected 0", pe_out); else passed++;
        total++; if (fe_out !== 1'b0) $display("[TB] FAIL reset_fe: got %b expected 0", fe_out); else passed++;
        total++; if (bi_out !== 1'b0) $display("[TB] FAIL reset_bi: got %b expected 0", bi_out); else passed++;
        total++; if (busy_out !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_out); else passed++;
        rstn_in = 1'b1;
        repeat (5) @(negedge bclk_in);
    endtask

    task automatic test_8n1;
        int v0;
        v0 = vcount;
        set_cfg(1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        drive_frame(8'hA5, 8, 1'b0, 1'b0, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL 8n1_valid_count: got %0d expected 1", vcount - v0); else passed++;
        total++; if (cap_rbr !== 8'hA5) $display("[TB] FAIL 8n1_rbr: got %h expected a5", cap_rbr); else passed++;
        total++; if ({cap_pe, cap_fe, cap_bi} !== 3'b000) $display("[TB] FAIL 8n1_flags: got %b expected 000", {cap_pe, cap_fe, cap_bi}); else passed++;
        total++; if (cap_lat !== 152) $display("[TB] FAIL 8n1_latency: got %0d expected 152", cap_lat); else passed++;
        total++; if (busy_out !== 1'b0) $display("[TB] FAIL 8n1_busy_after: got %b expected 0", busy_out); else passed++;
    endtask

    task automatic test_parity_n13;
        int v0;
        v0 = vcount;
        set_cfg(1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        drive_frame(8'h13, 5, 1'b1, 1'b1, 13, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL n13_valid_count: got %0d expected 1", vcount - v0); else passed++;
        total++; if (cap_rbr !== 8'h13) $display("[TB] FAIL n13_rbr: got %h expected 13", cap_rbr); else passed++;
        total++; if (cap_pe !== 1'b0) $display("[TB] FAIL n13_pe_good: got %b expected 0", cap_pe); else passed++;
        total++; if (cap_lat !== 98) $display("[TB] FAIL n13_latency: got %0d expected 98", cap_lat); else passed++;
        drive_frame(8'h13, 5, 1'b1, 1'b0, 13, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 2) $display("[TB] FAIL n13_valid_count2: got %0d expected 2", vcount - v0); else passed++;
        total++; if (cap_pe !== 1'b1) $display("[TB] FAIL n13_pe_flipped: got %b expected 1", cap_pe); else passed++;
        total++; if (cap_rbr !== 8'h13) $display("[TB] FAIL n13_rbr2: got %h expected 13", cap_rbr); else passed++;
    endtask

    task automatic test_stick_parity;
        set_cfg(1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
        drive_frame(8'h3C, 8, 1'b1, 1'b1, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (cap_pe !== 1'b1) $display("[TB] FAIL stick_pe_bit1: got %b expected 1", cap_pe); else passed++;
        total++; if (cap_rbr !== 8'h3C) $display("[TB] FAIL stick_rbr: got %h expected 3c", cap_rbr); else passed++;
        drive_frame(8'h3C, 8, 1'b1, 1'b0, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (cap_pe !== 1'b0) $display("[TB] FAIL stick_pe_bit0: got %b expected 0", cap_pe); else passed++;
        total++; if (cap_fe !== 1'b0) $display("[TB] FAIL stick_fe: got %b expected 0", cap_fe); else passed++;
    endtask

    task automatic test_false_start;
        int v0;
        int r0;
        v0 = vcount;
        r0 = rises;
        set_cfg(1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (4) @(negedge bclk_in);
        serial_in = 1'b1;
        repeat (24) @(negedge bclk_in);
        total++; if (rises - r0 !== 1) $display("[TB] FAIL glitch_busy_rise: got %0d expected 1", rises - r0); else passed++;
        total++; if (busy_out !== 1'b0) $display("[TB] FAIL glitch_busy_back: got %b expected 0", busy_out); else passed++;
        total++; if (vcount - v0 !== 0) $display("[TB] FAIL glitch_no_valid: got %0d expected 0", vcount - v0); else passed++;
    endtask

    task automatic test_break;
        int v0;
        v0 = vcount;
        serial_in = 1'b0;
        repeat (320) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL break_valid_count: got %0d expected 1", vcount - v0); else passed++;
        total++; if (cap_rbr !== 8'h00) $display("[TB] FAIL break_rbr: got %h expected 00", cap_rbr); else passed++;
        total++; if ({cap_fe, cap_bi} !== 2'b11) $display("[TB] FAIL break_fe_bi: got %b expected 11", {cap_fe, cap_bi}); else passed++;
        serial_in = 1'b1;
        repeat (20) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL break_no_retrigger: got %0d expected 1", vcount - v0); else passed++;
        drive_frame(8'h5A, 8, 1'b0, 1'b0, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 2) $display("[TB] FAIL break_next_count: got %0d expected 2", vcount - v0); else passed++;
        total++; if ({cap_rbr, cap_fe, cap_bi} !== {8'h5A, 2'b00}) $display("[TB] FAIL break_next_frame: got %h/%b%b expected 5a/00", cap_rbr, cap_fe, cap_bi); else passed++;
    endtask

    task automatic test_abort_enable;
        int v0;
        v0 = vcount;
        drive_frame(8'hC3, 8, 1'b0, 1'b0, 16, 4);
        serial_in = 1'b0;
        repeat (5) @(negedge bclk_in);
        total++; if (busy_out !== 1'b1) $display("[TB] FAIL en_busy_mid: got %b expected 1", busy_out); else passed++;
        enable_in = 1'b0;
        @(negedge bclk_in);
        total++; if (busy_out !== 1'b0) $display("[TB] FAIL en_idle_next: got %b expected 0", busy_out); else passed++;
        serial_in = 1'b1;
        repeat (20) @(negedge bclk_in);
        enable_in = 1'b1;
        repeat (40) @(negedge bclk_in);
        total++; if (vcount - v0 !== 0) $display("[TB] FAIL en_no_valid: got %0d expected 0", vcount - v0); else passed++;
        total++; if (rbr_out !== 8'h5A) $display("[TB] FAIL en_rbr_held: got %h expected 5a", rbr_out); else passed++;
        drive_frame(8'h96, 8, 1'b0, 1'b0, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL en_next_count: got %0d expected 1", vcount - v0); else passed++;
        total++; if (cap_rbr !== 8'h96) $display("[TB] FAIL en_next_rbr: got %h expected 96", cap_rbr); else passed++;
    endtask

    task automatic test_abort_reset;
        int v0;
        v0 = vcount;
        drive_frame(8'h3C, 8, 1'b0, 1'b0, 16, 4);
        serial_in = 1'b1;
        repeat (5) @(negedge bclk_in);
        rstn_in = 1'b0;
        #1;
        total++; if (busy_out !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy_out); else passed++;
        total++; if (rbr_out !== 8'h00) $display("[TB] FAIL rst_rbr: got %h expected 00", rbr_out); else passed++;
        repeat (3) @(negedge bclk_in);
        rstn_in = 1'b1;
        repeat (40) @(negedge bclk_in);
        total++; if (vcount - v0 !== 0) $display("[TB] FAIL rst_no_valid: got %0d expected 0", vcount - v0); else passed++;
        drive_frame(8'h81, 8, 1'b0, 1'b0, 16, 99);
        repeat (6) @(negedge bclk_in);
        total++; if (vcount - v0 !== 1) $display("[TB] FAIL rst_next_count: got %0d expected 1", vcount - v0); else passed++;
        total++; if (cap_rbr !== 8'h81) $display("[TB] FAIL rst_next_rbr: got %h expected 81", cap_rbr); else passed++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rstn_in    = 1'b0;
        enable_in  = 1'b1;
        serial_in  = 1'b1;
        osm_sel_in = 1'b0;
        wls_in     = 2'd3;
        pen_in     = 1'b0;
        esp_in     = 1'b0;
        sp_in      = 1'b0;
        @(negedge bclk_in);
        test_reset();
        test_8n1();
        test_parity_n13();
        test_stick_parity();
        test_false_start();
        test_break();
        test_abort_enable();
        test_abort_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
